// File: rtl/id_ex_hazard_register_if.sv
// ID/EX boundary bundle: ID-stage controls/operands in, EX-stage copies and hazard feedback out.
// The master side is main_controller/ID; the slave side is the ID/EX register.
interface id_ex_hazard_register_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic                      flush;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic                      id_branch;
    logic                      id_memory_read;
    logic                      id_memory_to_register;
    logic                      id_memory_write;
    logic                      id_alu_source;
    logic                      id_register_write;
    logic [3:0]                id_alu_option;
    logic [1:0]                id_AuipcLui;
    logic [DATA_WIDTH-1:0]     id_pc;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [3:0]                id_funct;

    logic                      hazard_mux_enable;
    logic                      pc_write;
    logic                      if_id_write;
    logic [REG_ADDR_WIDTH-1:0] ex_rs1;
    logic [REG_ADDR_WIDTH-1:0] ex_rs2;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      ex_branch;
    logic                      ex_memory_read;
    logic                      ex_memory_to_register;
    logic                      ex_memory_write;
    logic                      ex_alu_source;
    logic                      ex_register_write;
    logic [3:0]                ex_alu_option;
    logic [1:0]                ex_AuipcLui;
    logic [DATA_WIDTH-1:0]     ex_pc;
    logic [DATA_WIDTH-1:0]     ex_rs1_data;
    logic [DATA_WIDTH-1:0]     ex_rs2_data;
    logic [DATA_WIDTH-1:0]     ex_imm;
    logic [3:0]                ex_funct;
    logic                      ex_valid;
    logic [CNT_WIDTH-1:0]      bubble_count;

    modport master (
        output flush, id_rs1, id_rs2, id_rd, id_branch, id_memory_read,
               id_memory_to_register, id_memory_write, id_alu_source,
               id_register_write, id_alu_option, id_AuipcLui, id_pc,
               id_rs1_data, id_rs2_data, id_imm, id_funct,
        input  hazard_mux_enable, pc_write, if_id_write, ex_rs1, ex_rs2, ex_rd,
               ex_branch, ex_memory_read, ex_memory_to_register, ex_memory_write,
               ex_alu_source, ex_register_write, ex_alu_option, ex_AuipcLui,
               ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_funct, ex_valid,
               bubble_count
    );

    modport slave (
        input  flush, id_rs1, id_rs2, id_rd, id_branch, id_memory_read,
               id_memory_to_register, id_memory_write, id_alu_source,
               id_register_write, id_alu_option, id_AuipcLui, id_pc,
               id_rs1_data, id_rs2_data, id_imm, id_funct,
        output hazard_mux_enable, pc_write, if_id_write, ex_rs1, ex_rs2, ex_rd,
               ex_branch, ex_memory_read, ex_memory_to_register, ex_memory_write,
               ex_alu_source, ex_register_write, ex_alu_option, ex_AuipcLui,
               ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_funct, ex_valid,
               bubble_count
    );
endinterface

// File: rtl/id_ex_hazard_register.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating counter of inserted bubbles.
module id_ex_hazard_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    id_ex_hazard_register_if.slave bus
);
    logic [REG_ADDR_WIDTH-1:0] ex_rs1_reg, ex_rs2_reg, ex_rd_reg;
    logic                      ex_branch_reg, ex_memory_read_reg, ex_memory_to_register_reg;
    logic                      ex_memory_write_reg, ex_alu_source_reg, ex_register_write_reg;
    logic [3:0]                ex_alu_option_reg;
    logic [1:0]                ex_AuipcLui_reg;
    logic [DATA_WIDTH-1:0]     ex_pc_reg, ex_rs1_data_reg, ex_rs2_data_reg, ex_imm_reg;
    logic [3:0]                ex_funct_reg;
    logic                      ex_valid_reg;
    logic [CNT_WIDTH-1:0]      bubble_count_reg;

    logic load_use;
    logic hazard;

    // The load in EX is the only producer whose result is not yet forwardable.
    always_comb begin
        load_use = ex_memory_read_reg & ex_valid_reg & (ex_rd_reg != '0) &
                   ((ex_rd_reg == bus.id_rs1) | (ex_rd_reg == bus.id_rs2));
        hazard   = load_use & ~bus.flush;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ex_rs1_reg                <= '0;
            ex_rs2_reg                <= '0;
            ex_rd_reg                 <= '0;
            ex_branch_reg             <= 1'b0;
            ex_memory_read_reg        <= 1'b0;
            ex_memory_to_register_reg <= 1'b0;
            ex_memory_write_reg       <= 1'b0;
            ex_alu_source_reg         <= 1'b0;
            ex_register_write_reg     <= 1'b0;
            ex_alu_option_reg         <= '0;
            ex_AuipcLui_reg           <= '0;
            ex_pc_reg                 <= '0;
            ex_rs1_data_reg           <= '0;
            ex_rs2_data_reg           <= '0;
            ex_imm_reg                <= '0;
            ex_funct_reg              <= '0;
            ex_valid_reg              <= 1'b0;
            bubble_count_reg          <= '0;
        end else begin
            // Data fields follow ID unless flushed; a flushed slot keeps stale data.
            if (!bus.flush) begin
                ex_rs1_reg      <= bus.id_rs1;
                ex_rs2_reg      <= bus.id_rs2;
                ex_rd_reg       <= bus.id_rd;
                ex_pc_reg       <= bus.id_pc;
                ex_rs1_data_reg <= bus.id_rs1_data;
                ex_rs2_data_reg <= bus.id_rs2_data;
                ex_imm_reg      <= bus.id_imm;
                ex_funct_reg    <= bus.id_funct;
            end
            if (bus.flush || hazard) begin
                ex_branch_reg             <= 1'b0;
                ex_memory_read_reg        <= 1'b0;
                ex_memory_to_register_reg <= 1'b0;
                ex_memory_write_reg       <= 1'b0;
                ex_alu_source_reg         <= 1'b0;
                ex_register_write_reg     <= 1'b0;
                ex_alu_option_reg         <= '0;
                ex_AuipcLui_reg           <= '0;
                ex_valid_reg              <= 1'b0;
            end else begin
                ex_branch_reg             <= bus.id_branch;
                ex_memory_read_reg        <= bus.id_memory_read;
                ex_memory_to_register_reg <= bus.id_memory_to_register;
                ex_memory_write_reg       <= bus.id_memory_write;
                ex_alu_source_reg         <= bus.id_alu_source;
                ex_register_write_reg     <= bus.id_register_write;
                ex_alu_option_reg         <= bus.id_alu_option;
                ex_AuipcLui_reg           <= bus.id_AuipcLui;
                ex_valid_reg              <= 1'b1;
            end
            if (hazard && (bubble_count_reg != {CNT_WIDTH{1'b1}}))
                bubble_count_reg <= bubble_count_reg + CNT_WIDTH'(1);
        end
    end

    assign bus.hazard_mux_enable     = hazard;
    assign bus.pc_write              = ~hazard;
    assign bus.if_id_write           = ~hazard;
    assign bus.ex_rs1                = ex_rs1_reg;
    assign bus.ex_rs2                = ex_rs2_reg;
    assign bus.ex_rd                 = ex_rd_reg;
    assign bus.ex_branch             = ex_branch_reg;
    assign bus.ex_memory_read        = ex_memory_read_reg;
    assign bus.ex_memory_to_register = ex_memory_to_register_reg;
    assign bus.ex_memory_write       = ex_memory_write_reg;
    assign bus.ex_alu_source         = ex_alu_source_reg;
    assign bus.ex_register_write     = ex_register_write_reg;
    assign bus.ex_alu_option         = ex_alu_option_reg;
    assign bus.ex_AuipcLui           = ex_AuipcLui_reg;
    assign bus.ex_pc                 = ex_pc_reg;
    assign bus.ex_rs1_data           = ex_rs1_data_reg;
    assign bus.ex_rs2_data           = ex_rs2_data_reg;
    assign bus.ex_imm                = ex_imm_reg;
    assign bus.ex_funct              = ex_funct_reg;
    assign bus.ex_valid              = ex_valid_reg;
    assign bus.bubble_count          = bubble_count_reg;
endmodule
